// File: rtl/logic_lut_unit.sv
// Multi-channel programmable truth-table unit: registered valid/ready datapath,
// with per-channel tables reloaded through a serial config port that commits atomically.
module logic_lut_unit #(
    parameter int N_IN = 3,
    parameter int N_CH = 4,
    parameter logic [(2**N_IN)-1:0] RESET_TT = 8'hF5,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*N_IN-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH-1:0]        out_data,
    input  logic                   cfg_start,
    input  logic [CW-1:0]          cfg_ch,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_busy,
    output logic                   cfg_done
);

    localparam int TW   = 2**N_IN;
    localparam int CNTW = $clog2(TW) + 1;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its data stay stable until that transfer completes.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } cfg_state_t;

    cfg_state_t      state_q, state_nxt;
    logic [CW-1:0]   ch_q, ch_nxt;
    logic [CNTW-1:0] cnt_q, cnt_nxt;
    logic [TW-1:0]   shadow_q, shadow_nxt;
    logic            done_q;

    logic [TW-1:0]   tbl_q [N_CH];
    logic [N_CH-1:0] lut_out;
    logic            accept;

    // ------------------------------------------------------------------
    // Config FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ch_q     <= ch_nxt;
            cnt_q    <= cnt_nxt;
            shadow_q <= shadow_nxt;
            done_q   <= (state_q == S_COMMIT);
        end
    end

    always_comb begin
        state_nxt  = state_q;
        ch_nxt     = ch_q;
        cnt_nxt    = cnt_q;
        shadow_nxt = shadow_q;
        case (state_q)
            S_IDLE: begin
                // A start arriving in the cfg_done cycle is dropped on purpose.
                if (cfg_start && !done_q) begin
                    state_nxt  = S_SHIFT;
                    ch_nxt     = cfg_ch;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end
            end
            S_SHIFT: begin
                if (cfg_start) begin
                    ch_nxt     = cfg_ch;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end else if (cfg_valid) begin
                    shadow_nxt = {shadow_q[TW-2:0], cfg_bit};
                    cnt_nxt    = cnt_q + 1'b1;
                    if (cnt_q == CNTW'(TW - 1)) begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign cfg_busy = (state_q != S_IDLE);
    assign cfg_done = done_q;

    // ------------------------------------------------------------------
    // Truth tables; an out-of-range channel simply matches no entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                tbl_q[k] <= RESET_TT;
            end
        end else if (state_q == S_COMMIT) begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_q == CW'(k)) begin
                    tbl_q[k] <= shadow_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        lut_out = '0;
        for (int k = 0; k < N_CH; k++) begin
            lut_out[k] = tbl_q[k][in_data[k*N_IN +: N_IN]];
        end
    end

    // Blocking input during COMMIT keeps every sample on a whole table.
    assign in_ready = (!out_valid || out_ready) && (state_q != S_COMMIT);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lut_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_lut_unit.sv
// Scoreboarded bench for logic_lut_unit: random and directed traffic checked
// against a table-lookup reference model held in the bench.
module tb_logic_lut_unit;

  localparam int N_IN = 3;
  localparam int N_CH = 4;
  localparam int TW   = 8;
  localparam int CW   = 2;
  localparam int DW   = N_CH * N_IN;
  localparam logic [TW-1:0] RESET_TT = 8'hF5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N_CH-1:0] out_data;
  logic          cfg_start;
  logic [CW-1:0] cfg_ch;
  logic          cfg_valid;
  logic          cfg_bit;
  logic          cfg_busy;
  logic          cfg_done;

  logic [N_CH-1:0] exp_q[$];
  logic [TW-1:0]   ref_tt [N_CH];
  int n_checks;
  int n_errors;

  logic            prev_hold;
  logic [N_CH-1:0] prev_data;

  logic_lut_unit #(.N_IN(N_IN), .N_CH(N_CH), .RESET_TT(RESET_TT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_start(cfg_start), .cfg_ch(cfg_ch), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] model(input logic [DW-1:0] d);
    logic [N_CH-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = int'((d >> (k * N_IN)) & DW'(TW - 1));
      r[k] = ref_tt[k][idx];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) ref_tt[k] = RESET_TT;
  endtask

  // ---------------- scoreboard: push on accept, pop on output ----------------
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(model(in_data));
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_start = 1'b0; cfg_ch = '0; cfg_valid = 1'b0; cfg_bit = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_stream(input int cycles, input int ready_pct);
    repeat (cycles) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Loads val into channel ch MSB first with random gaps; pre_bits > 0 first
  // shifts junk bits and restarts with a start colliding with a valid bit.
  task automatic cfg_load(input int ch, input logic [TW-1:0] val, input int pre_bits);
    int busy_cycles;
    int gap;
    busy_cycles = 0;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_ch = CW'(ch);
    if (pre_bits > 0) begin
      @(posedge clk); #1;
      cfg_start = 1'b0;
      for (int i = 0; i < pre_bits; i++) begin
        cfg_valid = 1'b1; cfg_bit = 1'($urandom);
        check("busy_pre", 32'(cfg_busy), 32'd1);
        @(posedge clk); #1;
      end
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    end
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_valid = 1'b0;
    for (int i = TW - 1; i >= 0; i--) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        check("busy_gap", 32'(cfg_busy), 32'd1);
        busy_cycles++;
        @(posedge clk); #1;
      end
      cfg_valid = 1'b1; cfg_bit = val[i];
      check("busy_shift", 32'(cfg_busy), 32'd1);
      busy_cycles++;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
    end
    #1;
    check("busy_commit", 32'(cfg_busy), 32'd1);
    check("in_ready_commit", 32'(in_ready), 32'd0);
    check("done_in_commit", 32'(cfg_done), 32'd0);
    busy_cycles++;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    if (ch < N_CH) ref_tt[ch] = val;
    check("done_pulse", 32'(cfg_done), 32'd1);
    check("busy_after_commit", 32'(cfg_busy), 32'd0);
    check("busy_length_ge", 32'(busy_cycles >= TW + 1), 32'd1);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("start_ignored_busy", 32'(cfg_busy), 32'd0);
    check("done_one_cycle", 32'(cfg_done), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0] d;
    n_checks = 0;
    n_errors = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    apply_reset();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: ch0 indices 0..7 at full throughput
    for (int i = 0; i < TW; i++) begin
      @(posedge clk); #1;
      d = DW'($urandom);
      d[N_IN-1:0] = N_IN'(i);
      in_valid = 1'b1; in_data = d; out_ready = 1'b1;
      check("full_rate_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // 2: back-pressure with two samples offered
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; d = DW'($urandom); in_data = d;
    @(posedge clk); #1;
    check("bp_first_data", 32'(out_data), 32'(model(d)));
    in_data = DW'($urandom);
    repeat (3) begin
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // 3: load ch2 with XOR3 under random traffic, then probe index 7
    fork
      cfg_load(2, 8'h96, 0);
      random_stream(40, 70);
    join
    drain();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = {N_CH{3'b111}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // 4: restart after 5 partial bits, load 8'h01 into ch3
    cfg_load(3, 8'h01, 5);
    random_stream(20, 80);
    drain();

    // 5: continuous traffic straddling the commit of ch1
    fork
      cfg_load(1, TW'($urandom), 0);
      begin
        repeat (50) begin
          @(posedge clk); #1;
          in_valid = 1'b1; in_data = DW'($urandom); out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    join
    drain();
    cfg_load(0, TW'($urandom), 2);
    random_stream(30, 50);
    drain();

    // 6: reset mid-shift with an output held
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_ch = 2'd2;
    in_valid = 1'b1; in_data = DW'($urandom); out_ready = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'($urandom);
      @(posedge clk); #1;
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_busy", 32'(cfg_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_busy", 32'(cfg_busy), 32'd0);
    exp_q.delete();
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      check("no_done_after_rst", 32'(cfg_done), 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < TW; i++) begin
      in_valid = 1'b1; in_data = {N_CH{N_IN'(i)}}; out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    random_stream(30, 60);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
